// File: rtl/adam_rst_seq_pkg.sv
// Shared types and sizing helpers for the divided-domain reset/enable sequencer.
// Pure declarations: no logic, no latency, no flow control.
package adam_rst_seq_pkg;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        HOLD   = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        PAUSED = 3'd4,
        RESUME = 3'd5
    } rst_seq_state_e;

    // One counter serves both the reset stretch and the drain window, so size it for the larger.
    function automatic int cnt_width(input int rst_cycles, input int drain_cycles);
        int span;
        span = (rst_cycles > drain_cycles + 1) ? rst_cycles : drain_cycles + 1;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/adam_rst_sync.sv
// Reset synchroniser: async assert, release shifted through SYNC_STAGES flops.
// Release latency SYNC_STAGES rising edges; no flow control.
module adam_rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/adam_rst_seq.sv
// Local reset + clock-enable sequencer for a divided clock domain, with pause/resume handshake.
// Release SYNC_STAGES+RST_CYCLES edges; pause_req holds clk_en low until pause_ack has closed out.
module adam_rst_seq
    import adam_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RST_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pause_req,
    output logic rst_out_n,
    output logic clk_en,
    output logic pause_ack,
    output logic ready
);

    localparam int CNT_W = cnt_width(RST_CYCLES, DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);

    logic           rel_sync;
    rst_seq_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           rst_out_q;
    logic           clk_en_q;
    logic           pause_ack_q;
    logic           ready_q;

    adam_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .sync_o  (rel_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET;
            cnt_q       <= '0;
            rst_out_q   <= 1'b0;
            clk_en_q    <= 1'b0;
            pause_ack_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                // The cycle that first observes the synchronised release is hold cycle one.
                RESET: begin
                    if (rel_sync) begin
                        if (RST_CYCLES == 1) begin
                            state_q   <= RUN;
                            cnt_q     <= '0;
                            rst_out_q <= 1'b1;
                            clk_en_q  <= 1'b1;
                            ready_q   <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        rst_out_q <= 1'b1;
                        clk_en_q  <= 1'b1;
                        ready_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (pause_req) begin
                        state_q  <= DRAIN;
                        cnt_q    <= '0;
                        clk_en_q <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                end
                // Drain always runs to completion so the 4-phase handshake never aborts.
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_q     <= PAUSED;
                        pause_ack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state_q     <= RESUME;
                        pause_ack_q <= 1'b0;
                    end
                end
                RESUME: begin
                    state_q  <= RUN;
                    clk_en_q <= 1'b1;
                    ready_q  <= 1'b1;
                end
                default: begin
                    state_q <= RESET;
                end
            endcase
        end
    end

    assign rst_out_n = rst_out_q;
    assign clk_en    = clk_en_q;
    assign pause_ack = pause_ack_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Bench for adam_rst_seq: default build on the undivided clock, corner build on a divide-by-3 clock.
`timescale 1ns/1ps
module tb_adam_rst_seq;

    logic clk      = 1'b0;
    logic clk_div3 = 1'b0;
    logic rst_n       = 1'b0;
    logic pause_req   = 1'b0;
    logic rst_n_c     = 1'b0;
    logic pause_req_c = 1'b0;

    logic d_rst_out_n, d_clk_en, d_pause_ack, d_ready;
    logic c_rst_out_n, c_clk_en, c_pause_ack, c_ready;

    always #2.5 clk = ~clk;
    initial begin
        #2.5;
        forever begin
            clk_div3 = ~clk_div3;
            #7.5;
        end
    end

    adam_rst_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause_req (pause_req),
        .rst_out_n (d_rst_out_n),
        .clk_en    (d_clk_en),
        .pause_ack (d_pause_ack),
        .ready     (d_ready)
    );

    adam_rst_seq #(
        .SYNC_STAGES  (3),
        .RST_CYCLES   (1),
        .DRAIN_CYCLES (0)
    ) dut_c (
        .clk       (clk_div3),
        .rst_n     (rst_n_c),
        .pause_req (pause_req_c),
        .rst_out_n (c_rst_out_n),
        .clk_en    (c_clk_en),
        .pause_ack (c_pause_ack),
        .ready     (c_ready)
    );

    wire [3:0] d_out = {d_rst_out_n, d_clk_en, d_pause_ack, d_ready};
    wire [3:0] c_out = {c_rst_out_n, c_clk_en, c_pause_ack, c_ready};

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output changes while out of reset must land exactly on the owning clock edge.
    realtime last_clk_t = 0.0;
    realtime last_div_t = 0.0;
    int glitch_d = 0;
    int glitch_c = 0;
    always @(posedge clk)      last_clk_t = $realtime;
    always @(posedge clk_div3) last_div_t = $realtime;
    always @(d_out) if (rst_n === 1'b1 && $realtime != last_clk_t) glitch_d++;
    always @(c_out) if (rst_n_c === 1'b1 && $realtime != last_div_t) glitch_c++;

    // Vector: inputs applied just after an edge; exp = {rst_out_n, clk_en, pause_ack, ready} after the next edge.
    typedef struct {
        logic       rst_n;
        logic       pause_req;
        logic [3:0] exp;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    logic [3:0] exp_q[$];
    int         id_q[$];

    always begin : sb_chk
        int n;
        logic [3:0] e;
        int id;
        @(posedge clk);
        n = exp_q.size();
        #3;
        if (n > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            chk($sformatf("vec%0d", id), d_out, e);
        end
    end

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk);
            #1;
            rst_n     = vecs[i].rst_n;
            pause_req = vecs[i].pause_req;
            exp_q.push_back(vecs[i].exp);
            id_q.push_back(i);
        end
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #4;
        chk("sb_drain", exp_q.size(), 0);
    endtask

    task automatic div_edge();
        @(posedge clk_div3);
        #3;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Release, first pause, then a pause withdrawn during drain.
        vecs[0]  = '{1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 4'b0000};
        vecs[4]  = '{1'b1, 1'b0, 4'b0000};
        vecs[5]  = '{1'b1, 1'b0, 4'b0000};
        vecs[6]  = '{1'b1, 1'b0, 4'b0000};
        vecs[7]  = '{1'b1, 1'b0, 4'b1101};
        vecs[8]  = '{1'b1, 1'b0, 4'b1101};
        vecs[9]  = '{1'b1, 1'b1, 4'b1000};
        vecs[10] = '{1'b1, 1'b1, 4'b1000};
        vecs[11] = '{1'b1, 1'b1, 4'b1000};
        vecs[12] = '{1'b1, 1'b1, 4'b1010};
        vecs[13] = '{1'b1, 1'b1, 4'b1010};
        vecs[14] = '{1'b1, 1'b0, 4'b1000};
        vecs[15] = '{1'b1, 1'b0, 4'b1101};
        vecs[16] = '{1'b1, 1'b0, 4'b1101};
        vecs[17] = '{1'b1, 1'b1, 4'b1000};
        vecs[18] = '{1'b1, 1'b0, 4'b1000};
        vecs[19] = '{1'b1, 1'b0, 4'b1000};
        vecs[20] = '{1'b1, 1'b0, 4'b1010};
        vecs[21] = '{1'b1, 1'b0, 4'b1000};
        vecs[22] = '{1'b1, 1'b0, 4'b1101};
        // Re-release after a mid-op reset with pause_req already high.
        vecs[23] = '{1'b1, 1'b1, 4'b0000};
        vecs[24] = '{1'b1, 1'b1, 4'b0000};
        vecs[25] = '{1'b1, 1'b1, 4'b0000};
        vecs[26] = '{1'b1, 1'b1, 4'b0000};
        vecs[27] = '{1'b1, 1'b1, 4'b0000};
        vecs[28] = '{1'b1, 1'b1, 4'b1101};
        vecs[29] = '{1'b1, 1'b1, 4'b1000};
        vecs[30] = '{1'b1, 1'b1, 4'b1000};
        vecs[31] = '{1'b1, 1'b1, 4'b1000};
        vecs[32] = '{1'b1, 1'b1, 4'b1010};
        vecs[33] = '{1'b1, 1'b0, 4'b1000};
        vecs[34] = '{1'b1, 1'b0, 4'b1101};

        #1;
        chk("reset_state", d_out, 4'b0000);
        chk("reset_state_c", c_out, 4'b0000);

        run_vecs(0, 23);

        // Enter PAUSED, then pull rst_n mid-cycle: outputs must clear with no clock edge.
        @(posedge clk);
        #1;
        pause_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("paused_before_reset", d_out, 4'b1010);
        rst_n = 1'b0;
        #1;
        chk("async_reset", d_out, 4'b0000);

        run_vecs(23, NV);

        // Corner build on the divided clock: 4-edge release, 1-cycle ack.
        @(posedge clk_div3);
        #1;
        rst_n_c = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            div_edge();
            chk($sformatf("c_release_edge%0d", e), c_out, 4'b0000);
        end
        div_edge();
        chk("c_release_edge4", c_out, 4'b1101);
        pause_req_c = 1'b1;
        div_edge();
        chk("c_clk_en_fall", c_out, 4'b1000);
        div_edge();
        chk("c_ack_rise", c_out, 4'b1010);
        pause_req_c = 1'b0;
        div_edge();
        chk("c_ack_fall", c_out, 4'b1000);
        div_edge();
        chk("c_resume", c_out, 4'b1101);

        chk("edge_only_default", glitch_d, 0);
        chk("edge_only_div3", glitch_c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
